// File: rtl/uart_rx.sv
// uart_rx: oversampled serial receiver for 8N1 / 8E1 / 8O1 frames, LSB first.
// Latency: result pulse (9+PAR_EN)*OVERSAMPLE + OVERSAMPLE/2 clk after the first synchronized low
//          (one more clk when UART_RX_GLITCH_FILTER_EN is defined).
// Backpressure: none; the serial line cannot be stalled, results are one-cycle pulses, P_DATA holds.
//
// Build option: define UART_RX_GLITCH_FILTER_EN to decide each bit by a 3-sample majority vote
// around the bit centre; left undefined, each bit is a single sample at the centre count.
//
// Ports:
//   clk        sole clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   RX_IN      serial line, idle high (synchronized internally)
//   PAR_EN     1 = frame carries a parity bit (latched at frame start)
//   PAR_TYP    0 = even parity, 1 = odd parity (latched at frame start)
//   P_DATA     last correctly received byte
//   data_valid one-cycle pulse per good frame
//   par_err    one-cycle pulse on a parity mismatch
//   stp_err    one-cycle pulse when the stop bit samples 0 (wins over par_err)
//   busy       high whenever the receiver is not idle
module uart_rx #(
    parameter int OVERSAMPLE = 8    // clk cycles per serial bit; even, at least 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       data_valid,
    output logic       par_err,
    output logic       stp_err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);

    // Counter value of the last cycle of a bit, and of the bit centre.
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);

`ifdef UART_RX_GLITCH_FILTER_EN
    // Votes are collected at mid-1 and mid; the decision is taken at mid+1.
    localparam logic [CW-1:0] CNT_PRE    = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] CNT_DECIDE = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] CNT_DECIDE = CNT_MID;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t        state_q, state_d;

    logic [1:0]    sync_q;
    logic          rx_s;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_en_q, par_en_d;
    logic          par_typ_q, par_typ_d;
    logic          par_flag_q, par_flag_d;
    logic [7:0]    pdata_q, pdata_d;
    logic          dv_q, dv_d;
    logic          pe_q, pe_d;
    logic          se_q, se_d;

    logic          bit_end;     // last cycle of the current bit
    logic          decide;      // cycle on which the current bit value is resolved
    logic          bit_val;     // resolved value of the current bit

    // ------------------------------------------------------------------
    // Two-flop synchronizer; resets to the idle (high) line level so a
    // reset never looks like a start edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx_s = sync_q[1];

    // ------------------------------------------------------------------
    // Bit value resolution
    // ------------------------------------------------------------------
`ifdef UART_RX_GLITCH_FILTER_EN
    logic [1:0] vote_q, vote_d;

    always_comb begin
        vote_d = vote_q;
        if (state_q != S_IDLE) begin
            if (cnt_q == CNT_PRE) begin
                vote_d[0] = rx_s;
            end
            if (cnt_q == CNT_MID) begin
                vote_d[1] = rx_s;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_q <= 2'b11;
        end else begin
            vote_q <= vote_d;
        end
    end

    // Majority of the samples at mid-1, mid and the live one at mid+1.
    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign bit_end = (cnt_q == CNT_LAST);
    assign decide  = (cnt_q == CNT_DECIDE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // A start bit that reads high at its centre was noise.
                if (decide && bit_val) begin
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (idx_q == 3'd7)) begin
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leave mid stop bit so a back-to-back start edge is not missed.
                if (decide) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The frame verdict is resolved at the stop-bit decision
    // and registered, so exactly one pulse appears on the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != S_IDLE);
        dv_d = 1'b0;
        pe_d = 1'b0;
        se_d = 1'b0;
        if ((state_q == S_STOP) && decide) begin
            if (!bit_val) begin
                se_d = 1'b1;
            end else if (par_flag_q) begin
                pe_d = 1'b1;
            end else begin
                dv_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath next state: bit timing, shift register, parity tracking
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_flag_d = par_flag_q;
        pdata_d    = pdata_q;

        if (state_q == S_IDLE) begin
            cnt_d = '0;
            idx_d = '0;
            // Frame options are frozen at the start edge for the whole frame.
            if (!rx_s) begin
                par_en_d   = PAR_EN;
                par_typ_d  = PAR_TYP;
                par_flag_d = 1'b0;
            end
        end else begin
            if (bit_end || (state_d == S_IDLE)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            if (state_q == S_DATA) begin
                if (decide) begin
                    shift_d[idx_q] = bit_val;
                end
                if (bit_end) begin
                    idx_d = idx_q + 1'b1;
                end
            end

            if ((state_q == S_PARITY) && decide) begin
                par_flag_d = (bit_val != ((^shift_q) ^ par_typ_q));
            end
        end

        // Errored frames leave the last good byte in place.
        if (dv_d) begin
            pdata_d = shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag_q <= 1'b0;
            pdata_q    <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_flag_q <= par_flag_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            pe_q       <= pe_d;
            se_q       <= se_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames from a serial TX model into uart_rx, checked every cycle against a
// sample-time model of the receiver, plus hand-computed literal expectations per scenario.
// Ends with a single summary line.
module tb_uart_rx;

    localparam int OS = 8;
`ifdef UART_RX_GLITCH_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Rising-edge counter used for latency measurement.
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ------------------------------------------------------------------
    // Receiver model. It keeps the synchronized line history of the current
    // frame and resolves bit b at edge b*OS + OS/2 after start detection
    // (one later, as a 3-sample majority, with the glitch filter).
    // ------------------------------------------------------------------
    logic       d1 = 1'b1, d2 = 1'b1, rs;
    logic       m_busy = 1'b0, m_dv = 1'b0, m_pe = 1'b0, m_se = 1'b0;
    logic [7:0] m_pdata = 8'h00, m_byte = 8'h00;
    logic       m_pen = 1'b0, m_ptyp = 1'b0, m_pflag = 1'b0;
    logic       hist [0:255];
    int         m_k = 0;

    function automatic logic maj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            d1 = 1'b1; d2 = 1'b1;
            m_busy = 1'b0; m_dv = 1'b0; m_pe = 1'b0; m_se = 1'b0;
            m_pdata = 8'h00;
        end else begin
            int  b, rel;
            logic v;
            rs = d2; d2 = d1; d1 = RX_IN;
            m_dv = 1'b0; m_pe = 1'b0; m_se = 1'b0;
            if (!m_busy) begin
                if (rs == 1'b0) begin
                    m_busy = 1'b1; m_k = 0; hist[0] = rs;
                    m_pen = PAR_EN; m_ptyp = PAR_TYP; m_pflag = 1'b0;
                end
            end else begin
                m_k++;
                if (m_k < 256) hist[m_k] = rs;
                rel = m_k - OS / 2 - FILT;
                if (rel >= 0 && (rel % OS) == 0 && m_k < 256) begin
                    b = rel / OS;
                    v = (FILT != 0) ? maj(hist[m_k-2], hist[m_k-1], hist[m_k]) : rs;
                    if (b == 0) begin
                        if (v) m_busy = 1'b0;
                    end else if (b <= 8) begin
                        m_byte[b-1] = v;
                    end else if (b == 9 && m_pen) begin
                        m_pflag = (v != ((^m_byte) ^ m_ptyp));
                    end else begin
                        m_busy = 1'b0;
                        if (!v)          m_se = 1'b1;
                        else if (m_pflag) m_pe = 1'b1;
                        else begin
                            m_dv = 1'b1;
                            m_pdata = m_byte;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (run_cmp && !rst) begin
            check("cyc_data_valid", int'(data_valid), int'(m_dv));
            check("cyc_par_err",    int'(par_err),    int'(m_pe));
            check("cyc_stp_err",    int'(stp_err),    int'(m_se));
            check("cyc_busy",       int'(busy),       int'(m_busy));
            check("cyc_P_DATA",     int'(P_DATA),     int'(m_pdata));
        end
    end

    // Pulse bookkeeping for the literal scenario checks.
    int         dv_cnt = 0, pe_cnt = 0, se_cnt = 0, dv_cyc = 0;
    bit         busy_seen = 1'b0;
    logic [7:0] got_q [$];
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (data_valid) begin
                dv_cnt++;
                dv_cyc = cyc;
                got_q.push_back(P_DATA);
            end
            if (par_err) pe_cnt++;
            if (stp_err) se_cnt++;
            if (busy)    busy_seen = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Serial TX model. All tasks start and end 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    int frame_start_cyc = 0;

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        RX_IN = v;
        repeat (OS) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                              input logic bad_par, input logic stop_v, input logic flip);
        logic par;
        PAR_EN  = pe;
        PAR_TYP = pt;
        par = (^d) ^ pt ^ bad_par;
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (flip && i == 4) begin
                PAR_EN  = ~pe;
                PAR_TYP = ~pt;
            end
            drive_bit(d[i]);
        end
        if (pe) drive_bit(par);
        drive_bit(stop_v);
        PAR_EN  = pe;
        PAR_TYP = pt;
    endtask

    // Safety net: the stimulus is purely time-driven, this only guards a broken build.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv0, pe0, se0;
        logic [7:0] sent_q [$];
        logic [7:0] d;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_P_DATA",     int'(P_DATA),     0);
        check("rst_data_valid", int'(data_valid), 0);
        check("rst_par_err",    int'(par_err),    0);
        check("rst_stp_err",    int'(stp_err),    0);
        check("rst_busy",       int'(busy),       0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_cmp = 1'b1;
        idle(5);

        // 0xA5, no parity. Start detect is 3 edges after the line falls
        // (two synchronizer flops, then the edge that sees rx_s low); the
        // pulse follows 9*8+4 = 76 edges later.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("a5_dv_count", dv_cnt - dv0, 1);
        check("a5_P_DATA",   int'(P_DATA), 'hA5);
        check("a5_latency",  dv_cyc - frame_start_cyc, 3 + 76 + FILT);
        check("a5_no_err",   (pe_cnt - pe0) + (se_cnt - se0), 0);

        // 0x03, even parity, wrong parity bit 1 -> par_err, P_DATA kept.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(4);
        check("par_pe_count", pe_cnt - pe0, 1);
        check("par_dv_count", dv_cnt - dv0, 0);
        check("par_P_DATA",   int'(P_DATA), 'hA5);

        // 0x5A with stop 0, then 0x3C immediately.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(10);
        check("stp_se_count", se_cnt - se0, 1);
        check("stp_pe_count", pe_cnt - pe0, 0);
        check("stp_dv_count", dv_cnt - dv0, 1);
        check("stp_P_DATA",   int'(P_DATA), 'h3C);

        // 2-cycle low glitch on the idle line -> false start.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        busy_seen = 1'b0;
        RX_IN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(20);
        check("glitch_busy_seen", int'(busy_seen), 1);
        check("glitch_busy_now",  int'(busy), 0);
        check("glitch_no_pulse",  (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);

        // Parity options flipped mid-frame must be ignored: 0x96, odd parity.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(4);
        check("flip_dv_count", dv_cnt - dv0, 1);
        check("flip_P_DATA",   int'(P_DATA), 'h96);

        // Reset during D4 of a frame.
        PAR_EN = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        RX_IN = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_P_DATA",     int'(P_DATA),     0);
        check("midrst_data_valid", int'(data_valid), 0);
        check("midrst_par_err",    int'(par_err),    0);
        check("midrst_stp_err",    int'(stp_err),    0);
        check("midrst_busy",       int'(busy),       0);
        RX_IN = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        idle(20);
        check("postrst_idle", int'(busy), 0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("postrst_dv_count", dv_cnt - dv0, 1);
        check("postrst_P_DATA",   int'(P_DATA), 'h81);

`ifdef UART_RX_GLITCH_FILTER_EN
        // 1-cycle low glitch at the centre of D3 of 0xFF is voted out.
        dv0 = dv_cnt;
        PAR_EN = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                RX_IN = 1'b1;
                repeat (OS / 2) @(posedge clk);
                #1 RX_IN = 1'b0;
                @(posedge clk);
                #1 RX_IN = 1'b1;
                repeat (OS / 2 - 1) @(posedge clk);
                #1;
            end else begin
                drive_bit(1'b1);
            end
        end
        drive_bit(1'b1);
        idle(4);
        check("filt_dv_count", dv_cnt - dv0, 1);
        check("filt_P_DATA",   int'(P_DATA), 'hFF);
`endif

        // Ten back-to-back parity frames, alternating even/odd, random data.
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            sent_q.push_back(d);
            send_frame(d, 1'b1, 1'(i % 2), 1'b0, 1'b1, 1'b0);
        end
        idle(20);
        check("b2b_dv_count", dv_cnt - dv0, 10);
        check("b2b_no_err",   (pe_cnt - pe0) + (se_cnt - se0), 0);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("b2b_byte%0d", i), int'(got_q[i]), int'(sent_q[i]));
            end else begin
                check($sformatf("b2b_byte%0d_missing", i), got_q.size(), i + 1);
            end
        end

        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
